// File: rtl/tlb_set_ctrl.sv
// Lookup/refill controller for a set-associative TLB: owns valid/tag/PPN state,
// serves hits from storage and refills misses through the page-table walker.
module tlb_set_ctrl #(
  parameter int SETS  = 4,
  parameter int WAYS  = 2,
  parameter int VPN_W = 20,
  parameter int PPN_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VPN_W-1:0] req_vpn,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_hit,
  output logic             resp_fault,
  output logic             walk_req_valid,
  input  logic             walk_req_ready,
  output logic [VPN_W-1:0] walk_req_vpn,
  input  logic             walk_resp_valid,
  input  logic [PPN_W-1:0] walk_resp_ppn,
  input  logic             walk_resp_fault,
  input  logic             flush,
  output logic             busy
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WALK_REQ  = 3'd2,
    WALK_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5
  } state_t;

  state_t            state_r;
  logic [WAYS-1:0]   valid_r [SETS];
  logic [TAG_W-1:0]  tag_r   [SETS][WAYS];
  logic [PPN_W-1:0]  ppn_r   [SETS][WAYS];
  logic [WAY_W-1:0]  ptr_r   [SETS];
  logic [VPN_W-1:0]  vpn_r;
  logic [PPN_W-1:0]  fill_ppn_r;
  logic              flush_pending_r;

  logic [IDX_W-1:0]  set_s;
  logic [TAG_W-1:0]  tag_s;
  logic [WAYS-1:0]   hit_vec_s;
  logic              hit_s;
  logic [PPN_W-1:0]  hit_ppn_s;
  logic [WAYS-1:0]   inv_s;
  logic              have_inv_s;
  logic [WAY_W-1:0]  victim_s;
  logic [WAY_W-1:0]  ptr_next_s;

  assign set_s = vpn_r[IDX_W-1:0];
  assign tag_s = vpn_r[VPN_W-1:IDX_W];

  // Tag compare across the set; at most one way can match, so the PPN is an OR-merge
  always_comb begin
    hit_vec_s = '0;
    hit_ppn_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_r[set_s][w] && (tag_r[set_s][w] == tag_s);
      hit_ppn_s    = hit_ppn_s | (hit_vec_s[w] ? ppn_r[set_s][w] : {PPN_W{1'b0}});
    end
    hit_s = |hit_vec_s;
  end

  // Victim selection: lowest invalid way, else the round-robin pointer
  always_comb begin
    inv_s      = ~valid_r[set_s];
    have_inv_s = |inv_s;
    victim_s   = ptr_r[set_s];
    for (int w = WAYS - 1; w >= 0; w--) begin
      victim_s = inv_s[w] ? WAY_W'(w) : victim_s;
    end
    ptr_next_s = (ptr_r[set_s] == WAY_W'(WAYS - 1)) ? {WAY_W{1'b0}} : (ptr_r[set_s] + WAY_W'(1));
  end

  assign req_ready = rst_n && (state_r == IDLE) && !flush && !flush_pending_r;
  assign busy      = (state_r != IDLE) || flush_pending_r;

  // Control FSM together with storage updates and registered response/walk outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      vpn_r           <= '0;
      fill_ppn_r      <= '0;
      flush_pending_r <= 1'b0;
      resp_valid      <= 1'b0;
      resp_ppn        <= '0;
      resp_hit        <= 1'b0;
      resp_fault      <= 1'b0;
      walk_req_valid  <= 1'b0;
      walk_req_vpn    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        ptr_r[s]   <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_r[s][w] <= '0;
          ppn_r[s][w] <= '0;
        end
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (flush || flush_pending_r) begin
            for (int s = 0; s < SETS; s++) begin
              valid_r[s] <= '0;
              ptr_r[s]   <= '0;
            end
            flush_pending_r <= 1'b0;
          end else if (req_valid) begin
            vpn_r   <= req_vpn;
            state_r <= LOOKUP;
          end else begin
            state_r <= IDLE;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            resp_ppn   <= hit_ppn_s;
            resp_hit   <= 1'b1;
            resp_fault <= 1'b0;
            resp_valid <= 1'b1;
            state_r    <= RESP;
          end else begin
            walk_req_valid <= 1'b1;
            walk_req_vpn   <= vpn_r;
            state_r        <= WALK_REQ;
          end
        end
        WALK_REQ: begin
          if (walk_req_ready) begin
            walk_req_valid <= 1'b0;
            state_r        <= WALK_WAIT;
          end else begin
            state_r <= WALK_REQ;
          end
        end
        WALK_WAIT: begin
          if (walk_resp_valid && walk_resp_fault) begin
            resp_ppn   <= '0;
            resp_hit   <= 1'b0;
            resp_fault <= 1'b1;
            resp_valid <= 1'b1;
            state_r    <= RESP;
          end else if (walk_resp_valid) begin
            fill_ppn_r <= walk_resp_ppn;
            state_r    <= FILL;
          end else begin
            state_r <= WALK_WAIT;
          end
        end
        FILL: begin
          valid_r[set_s][victim_s] <= 1'b1;
          tag_r[set_s][victim_s]   <= tag_s;
          ppn_r[set_s][victim_s]   <= fill_ppn_r;
          if (!have_inv_s) begin
            ptr_r[set_s] <= ptr_next_s;
          end else begin
            ptr_r[set_s] <= ptr_r[set_s];
          end
          resp_ppn   <= fill_ppn_r;
          resp_hit   <= 1'b0;
          resp_fault <= 1'b0;
          resp_valid <= 1'b1;
          state_r    <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // A flush arriving mid-transaction is deferred to the next IDLE cycle
      if ((state_r != IDLE) && flush) begin
        flush_pending_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tlb_set_ctrl.sv
// Scoreboard bench for tlb_set_ctrl: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_tlb_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic        resp_valid;
  logic        resp_ready;
  logic [19:0] resp_ppn;
  logic        resp_hit;
  logic        resp_fault;
  logic        walk_req_valid;
  logic        walk_req_ready;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid;
  logic [19:0] walk_resp_ppn;
  logic        walk_resp_fault;
  logic        flush;
  logic        busy;

  int checks     = 0;
  int failures   = 0;
  int resp_count = 0;

  typedef struct packed {
    logic [19:0] ppn;
    logic        hit;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  tlb_set_ctrl #(.SETS(4), .WAYS(2), .VPN_W(20), .PPN_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ppn(resp_ppn),
    .resp_hit(resp_hit), .resp_fault(resp_fault),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready), .walk_req_vpn(walk_req_vpn),
    .walk_resp_valid(walk_resp_valid), .walk_resp_ppn(walk_resp_ppn), .walk_resp_fault(walk_resp_fault),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every response handshake pops one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      resp_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual_ppn=0x%0h required=none", resp_ppn);
      end else begin
        e = exp_q.pop_front();
        chk("resp_ppn", resp_ppn, e.ppn);
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_fault", resp_fault, e.fault);
      end
    end
  end

  task automatic do_req(input logic [19:0] vpn, input bit exp_walk,
                        input logic [19:0] wppn, input bit wfault,
                        input int wr_stall, input int rr_stall, input bit fl,
                        input logic [19:0] eppn, input bit ehit, input bit efault);
    int wr_cnt = 0;
    int rr_cnt = 0;
    int wphase = 0;
    int n0;
    bit seen_walk = 0;
    bit done = 0;
    bit acc = 0;
    bit hs, wv, rv;
    n0 = resp_count;
    exp_q.push_back({eppn, ehit, efault});
    walk_req_ready = (wr_stall == 0);
    resp_ready     = (rr_stall == 0);
    req_vpn   = vpn;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    for (int c = 1; c <= 100 && acc && !done; c++) begin
      @(negedge clk);
      wv = walk_req_valid;
      rv = resp_valid;
      hs = 1'b0;
      if (c == 2) begin
        chk("resp_valid_c2", resp_valid, ehit);
        chk("walk_req_c2", walk_req_valid, exp_walk);
      end
      if (wv) begin
        seen_walk = 1'b1;
        chk("walk_req_vpn", walk_req_vpn, vpn);
        hs = walk_req_ready;
      end
      if (fl && wphase == 1) chk("busy_flush", busy, 1);
      if (rv && !resp_ready) begin
        chk("stall_ppn", resp_ppn, eppn);
        chk("stall_hit", resp_hit, ehit);
        chk("stall_fault", resp_fault, efault);
      end else if (rv) begin
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (hs) begin
        walk_req_ready = 1'b0;
        wphase = 1;
        flush = fl;
      end else if (wv && !walk_req_ready) begin
        wr_cnt++;
        walk_req_ready = (wr_cnt >= wr_stall);
      end else if (wphase == 1) begin
        flush = 1'b0;
        walk_resp_valid = 1'b1;
        walk_resp_ppn   = wppn;
        walk_resp_fault = wfault;
        wphase = 2;
      end else if (wphase == 2) begin
        walk_resp_valid = 1'b0;
        wphase = 3;
      end
      if (rv && !resp_ready) begin
        rr_cnt++;
        resp_ready = (rr_cnt >= rr_stall);
      end
    end
    chk("walk_issued", seen_walk, exp_walk);
    chk("one_resp", resp_count - n0, 1);
    if (fl) begin
      @(negedge clk);
      chk("ready_flush_cycle", req_ready, 0);
      chk("busy_flush_cycle", busy, 1);
      @(negedge clk);
      chk("ready_after_flush", req_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_vpn = '0; resp_ready = 1'b1;
    walk_req_ready = 1'b0; walk_resp_valid = 1'b0; walk_resp_ppn = '0;
    walk_resp_fault = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_walk_req_valid", walk_req_valid, 0);
    chk("rst_resp_ppn", resp_ppn, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_walk_req_vpn", walk_req_vpn, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    @(posedge clk); #1;

    // cold miss then hit
    do_req(20'h00012, 1, 20'h0ABCD, 0, 0, 0, 0, 20'h0ABCD, 0, 0);
    do_req(20'h00012, 0, 20'h00000, 0, 0, 0, 0, 20'h0ABCD, 1, 0);

    // idle flush empties set 2 before the replacement sequence
    flush = 1'b1;
    @(negedge clk);
    chk("ready_during_flush", req_ready, 0);
    @(posedge clk); #1 flush = 1'b0;

    do_req(20'h00002, 1, 20'h00001, 0, 0, 0, 0, 20'h00001, 0, 0);
    do_req(20'h00006, 1, 20'h00002, 0, 0, 0, 0, 20'h00002, 0, 0);
    do_req(20'h0000A, 1, 20'h00003, 0, 0, 0, 0, 20'h00003, 0, 0);
    do_req(20'h00006, 0, 20'h00000, 0, 0, 0, 0, 20'h00002, 1, 0);
    do_req(20'h0000A, 0, 20'h00000, 0, 0, 0, 0, 20'h00003, 1, 0);
    do_req(20'h00002, 1, 20'h00001, 0, 0, 0, 0, 20'h00001, 0, 0);

    // walker fault: zero PPN, nothing filled
    do_req(20'h00100, 1, 20'h0DEAD, 1, 0, 0, 0, 20'h00000, 0, 1);
    do_req(20'h00100, 1, 20'h00777, 0, 0, 0, 0, 20'h00777, 0, 0);

    // backpressure on both walker and response
    do_req(20'h00035, 1, 20'h12345, 0, 5, 3, 0, 20'h12345, 0, 0);

    // flush during walk, then a previous hit must miss
    do_req(20'h00200, 1, 20'h00222, 0, 0, 0, 1, 20'h00222, 0, 0);
    do_req(20'h0000A, 1, 20'h00333, 0, 0, 0, 0, 20'h00333, 0, 0);

    // reset while a walk request is outstanding
    walk_req_ready = 1'b0;
    req_vpn = 20'h00035;
    req_valid = 1'b1;
    @(negedge clk);
    chk("ready_before_abort", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("walk_req_before_reset", walk_req_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("walk_req_in_reset", walk_req_valid, 0);
    chk("req_ready_in_reset", req_ready, 0);
    chk("busy_in_reset", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_req(20'h00035, 1, 20'h00444, 0, 0, 0, 0, 20'h00444, 0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
